nn_param_fifo: RTL and testbench
================================

NN_PARAM_FIFO -- requirements
Module: nn_param_fifo

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count; power of two, >= 2.
REQ-003 Parameter AFULL_TH, default 6, SHALL set the almost_full threshold; 1..DEPTH-1.
REQ-004 Parameter AEMPTY_TH, default 2, SHALL set the almost_empty threshold; 1..DEPTH-1.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 clr  in  1  synchronous flush.
REQ-009 wr_valid  in  1  push request.
REQ-010 wr_ready  out  1  space available.
REQ-011 wr_data  in  DATA_W  push data.
REQ-012 rd_valid  out  1  head word available.
REQ-013 rd_ready  in  1  pop request.
REQ-014 rd_data  out  DATA_W  head word.
REQ-015 level  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
REQ-016 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Push SHALL occur on a clk edge when wr_valid && wr_ready; pop SHALL occur when rd_valid && rd_ready.
REQ-019 wr_ready SHALL equal !full; rd_valid SHALL equal !empty. A push while full SHALL be refused even if a pop occurs in the same cycle.
REQ-020 rd_data SHALL present the oldest stored word combinationally from storage (show-ahead); a pushed word SHALL be visible on rd_data one cycle after its push edge.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits wide; the MSB SHALL be the wrap bit. full = (address bits equal, wrap bits differ); empty = (pointers equal).
REQ-022 level SHALL be wr_ptr - rd_ptr modulo 2^($clog2(DEPTH)+1), registered, with the same timing as the pointers.
REQ-023 Simultaneous push and pop when 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-024 almost_full SHALL equal (level >= AFULL_TH); almost_empty SHALL equal (level <= AEMPTY_TH).
REQ-025 overflow SHALL set on any edge with wr_valid && !wr_ready; underflow SHALL set on any edge with rd_ready && !rd_valid. Both SHALL hold until clr or reset.
REQ-026 clr SHALL take priority over push and pop in the same cycle: pointers, level, overflow and underflow go to 0. Storage contents SHALL NOT be cleared.
REQ-027 Pointer addresses SHALL wrap from DEPTH-1 to 0, toggling the wrap bit. No other wrap handling is required.

Reset
REQ-028 On rst_n low, pointers and level SHALL be 0, empty = 1, almost_empty = 1, full = almost_full = overflow = underflow = 0, wr_ready = 1, and rd_valid = 0, all asynchronously.
REQ-029 rd_data SHALL be don't-care while empty; storage SHALL NOT be reset.
REQ-030 Reset asserted mid-transfer SHALL discard all contents; the first pop after release SHALL return the first word pushed after release.

Structure
REQ-031 Package nn_fifo_pkg SHALL hold the pointer-width function and the default DATA_W/DEPTH constants shared with other nn blocks.
REQ-032 Storage SHALL be a sub-module nn_fifo_mem (DEPTH x DATA_W, one synchronous write port, one asynchronous read port). Control logic SHALL stay in nn_param_fifo.

Verification
REQ-033 Defaults; push 0x11..0x88 back-to-back -> full = 1 and level = 8 after the 8th edge, wr_ready = 0, almost_full set at level 6.
REQ-034 From full, pop 8 times with rd_ready = 1 -> rd_data reads 0x11..0x88 in order, empty = 1 after the 8th pop, almost_empty set at level 2.
REQ-035 Level 3; wr_valid = rd_ready = 1 for 20 cycles with incrementing data -> level stays 3, output order is preserved across pointer wrap.
REQ-036 Full FIFO: wr_valid = rd_ready = 1 together -> pop accepted, push refused, overflow = 1, level = 7. Next: rd_ready on empty -> underflow = 1.
REQ-037 Level 5 with overflow = 1; pulse clr with wr_valid = 1 -> level = 0, overflow = 0, empty = 1. rst_n pulsed mid-burst -> flags at reset values immediately, without waiting for a clk edge.
REQ-038 DATA_W = 16, DEPTH = 32 build -> 32 pushes reach full, level = 32, and wrap checks pass.

Source files
------------

// File: rtl/nn_fifo_pkg.sv
// ---------------------------------------------------------------------------
// nn_fifo_pkg
// Shared definitions for the nn FIFO family:
//   NN_DATA_W / NN_DEPTH : default word width and entry count used by nn blocks
//   nn_ptr_w()           : pointer width for a given depth (address bits + wrap bit)
//   nn_fifo_op_e         : per-cycle transfer decode {push, pop}
// ---------------------------------------------------------------------------
package nn_fifo_pkg;

    localparam int NN_DATA_W = 32;
    localparam int NN_DEPTH  = 8;

    // One extra MSB on top of the address lets full and empty be told apart
    // when the address bits of both pointers are equal.
    function automatic int nn_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } nn_fifo_op_e;

endpackage : nn_fifo_pkg

// File: rtl/nn_fifo_mem.sv
// ---------------------------------------------------------------------------
// nn_fifo_mem
// DEPTH x DATA_W storage array for nn_param_fifo.
// One synchronous write port and one asynchronous (combinational) read port.
// The array is deliberately not reset.
//   clk      in   write clock
//   wr_en    in   write strobe, sampled on rising clk
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  word at rd_addr, combinational
// ---------------------------------------------------------------------------
module nn_fifo_mem
    import nn_fifo_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int DEPTH  = NN_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Show-ahead read: the head word is visible without a read strobe.
    assign rd_data = mem[rd_addr];

endmodule : nn_fifo_mem

// File: rtl/nn_param_fifo.sv
// ---------------------------------------------------------------------------
// nn_param_fifo
// Parameterised synchronous show-ahead FIFO with level, threshold flags and
// sticky overflow/underflow detection. Storage lives in nn_fifo_mem; all
// pointer and flag control lives here.
//
// Parameters
//   DATA_W    word width
//   DEPTH     entry count, power of two, >= 2
//   AFULL_TH  almost_full when level >= AFULL_TH   (1..DEPTH-1)
//   AEMPTY_TH almost_empty when level <= AEMPTY_TH (1..DEPTH-1)
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   clr           in   synchronous flush (wins over push/pop)
//   wr_valid      in   push request
//   wr_ready      out  space available (!full)
//   wr_data       in   push data
//   rd_valid      out  head word available (!empty)
//   rd_ready      in   pop request
//   rd_data       out  head word, combinational from storage
//   level         out  occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   out  status flags
//   overflow      out  sticky: push attempted while full
//   underflow     out  sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module nn_param_fifo
    import nn_fifo_pkg::*;
#(
    parameter int DATA_W    = NN_DATA_W,
    parameter int DEPTH     = NN_DEPTH,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = nn_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] level_q;
    logic          push;
    logic          pop;
    logic          mem_wr_en;
    nn_fifo_op_e   op;

    // Status derived from the registered pointers, so an asynchronous reset
    // of the pointers drives every flag to its reset value immediately.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ready = !full;
    assign rd_valid = !empty;

    // A push is gated by full alone: a pop in the same cycle does not make
    // room for it.
    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;
    assign op   = nn_fifo_op_e'({push, pop});

    assign level        = level_q;
    assign almost_full  = (level_q >= AFULL_LV);
    assign almost_empty = (level_q <= AEMPTY_LV);

    // Natural binary increment: with DEPTH a power of two the address bits
    // roll from DEPTH-1 to 0 and the carry toggles the wrap bit.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        case (op)
            OP_PUSH: wr_ptr_nxt = wr_ptr + PTR_ONE;
            OP_POP:  rd_ptr_nxt = rd_ptr + PTR_ONE;
            OP_BOTH: begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
                rd_ptr_nxt = rd_ptr + PTR_ONE;
            end
            default: begin
                wr_ptr_nxt = wr_ptr;
                rd_ptr_nxt = rd_ptr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            // Modular difference of the next pointers keeps level aligned
            // with the pointer registers cycle for cycle.
            level_q <= wr_ptr_nxt - rd_ptr_nxt;
            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
            if (rd_ready && !rd_valid) begin
                underflow <= 1'b1;
            end
        end
    end

    // A push coinciding with clr is dropped, so the array is left untouched.
    assign mem_wr_en = push && !clr;

    nn_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

endmodule : nn_param_fifo

// File: tb/tb_nn_param_fifo.sv
// ---------------------------------------------------------------------------
// tb_nn_param_fifo
// Two instances: default build (32 x 8) and a 16 x 32 build. A queue-based
// model of each FIFO is advanced on every rising edge; a negedge process
// compares every output against it. Directed sequences add literal checks.
// ---------------------------------------------------------------------------
module tb_nn_param_fifo;

    localparam int A_W  = 32;
    localparam int A_D  = 8;
    localparam int A_AF = 6;
    localparam int A_AE = 2;
    localparam int B_W  = 16;
    localparam int B_D  = 32;
    localparam int B_AF = 28;
    localparam int B_AE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic           a_clr = 1'b0, a_wv = 1'b0, a_rr = 1'b0;
    logic [A_W-1:0] a_wd  = '0;
    logic           a_wr_ready, a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [A_W-1:0] a_rd_data;
    logic [3:0]     a_level;

    logic           b_clr = 1'b0, b_wv = 1'b0, b_rr = 1'b0;
    logic [B_W-1:0] b_wd  = '0;
    logic           b_wr_ready, b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [B_W-1:0] b_rd_data;
    logic [5:0]     b_level;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    logic [A_W-1:0] qa[$];
    logic [B_W-1:0] qb[$];
    bit a_ovf_m = 1'b0, a_unf_m = 1'b0;
    bit b_ovf_m = 1'b0, b_unf_m = 1'b0;

    always #5 clk = ~clk;

    nn_param_fifo #(.DATA_W(A_W), .DEPTH(A_D), .AFULL_TH(A_AF), .AEMPTY_TH(A_AE)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr),
        .wr_valid(a_wv), .wr_ready(a_wr_ready), .wr_data(a_wd),
        .rd_valid(a_rd_valid), .rd_ready(a_rr), .rd_data(a_rd_data),
        .level(a_level), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf)
    );

    nn_param_fifo #(.DATA_W(B_W), .DEPTH(B_D), .AFULL_TH(B_AF), .AEMPTY_TH(B_AE)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .wr_valid(b_wv), .wr_ready(b_wr_ready), .wr_data(b_wd),
        .rd_valid(b_rd_valid), .rd_ready(b_rr), .rd_data(b_rd_data),
        .level(b_level), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural models: a queue plus two sticky bits per FIFO.
    task automatic model_a();
        bit do_push, do_pop;
        if (a_clr) begin
            qa.delete();
            a_ovf_m = 1'b0;
            a_unf_m = 1'b0;
        end else begin
            do_push = a_wv && (qa.size() < A_D);
            do_pop  = a_rr && (qa.size() > 0);
            if (a_wv && qa.size() == A_D) a_ovf_m = 1'b1;
            if (a_rr && qa.size() == 0)   a_unf_m = 1'b1;
            if (do_pop)  void'(qa.pop_front());
            if (do_push) qa.push_back(a_wd);
        end
    endtask

    task automatic model_b();
        bit do_push, do_pop;
        if (b_clr) begin
            qb.delete();
            b_ovf_m = 1'b0;
            b_unf_m = 1'b0;
        end else begin
            do_push = b_wv && (qb.size() < B_D);
            do_pop  = b_rr && (qb.size() > 0);
            if (b_wv && qb.size() == B_D) b_ovf_m = 1'b1;
            if (b_rr && qb.size() == 0)   b_unf_m = 1'b1;
            if (do_pop)  void'(qb.pop_front());
            if (do_push) qb.push_back(b_wd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            model_a();
            model_b();
        end
        #1;
    endtask

    task automatic set_a(input bit wv, input bit rr, input logic [31:0] wd, input bit c);
        a_wv = wv; a_rr = rr; a_wd = wd; a_clr = c;
    endtask

    task automatic set_b(input bit wv, input bit rr, input logic [15:0] wd, input bit c);
        b_wv = wv; b_rr = rr; b_wd = wd; b_clr = c;
    endtask

    task automatic reset_models();
        qa.delete(); qb.delete();
        a_ovf_m = 1'b0; a_unf_m = 1'b0;
        b_ovf_m = 1'b0; b_unf_m = 1'b0;
    endtask

    // Per-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("a_level",     32'(a_level),    32'(qa.size()));
            check("a_full",      32'(a_full),     32'(qa.size() == A_D));
            check("a_empty",     32'(a_empty),    32'(qa.size() == 0));
            check("a_wr_ready",  32'(a_wr_ready), 32'(qa.size() != A_D));
            check("a_rd_valid",  32'(a_rd_valid), 32'(qa.size() != 0));
            check("a_afull",     32'(a_af),       32'(qa.size() >= A_AF));
            check("a_aempty",    32'(a_ae),       32'(qa.size() <= A_AE));
            check("a_overflow",  32'(a_ovf),      32'(a_ovf_m));
            check("a_underflow", 32'(a_unf),      32'(a_unf_m));
            if (qa.size() > 0) check("a_rd_data", a_rd_data, qa[0]);
            check("b_level",     32'(b_level),    32'(qb.size()));
            check("b_full",      32'(b_full),     32'(qb.size() == B_D));
            check("b_empty",     32'(b_empty),    32'(qb.size() == 0));
            check("b_wr_ready",  32'(b_wr_ready), 32'(qb.size() != B_D));
            check("b_rd_valid",  32'(b_rd_valid), 32'(qb.size() != 0));
            check("b_afull",     32'(b_af),       32'(qb.size() >= B_AF));
            check("b_aempty",    32'(b_ae),       32'(qb.size() <= B_AE));
            check("b_overflow",  32'(b_ovf),      32'(b_ovf_m));
            check("b_underflow", 32'(b_unf),      32'(b_unf_m));
            if (qb.size() > 0) check("b_rd_data", 32'(b_rd_data), 32'(qb[0]));
        end
    end

    initial begin
        int pw, pr;
        logic [31:0] exp_w;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checking = 1'b1;

        // Reset state
        check("rst_level",    32'(a_level),    32'h0);
        check("rst_empty",    32'(a_empty),    32'h1);
        check("rst_aempty",   32'(a_ae),       32'h1);
        check("rst_full",     32'(a_full),     32'h0);
        check("rst_afull",    32'(a_af),       32'h0);
        check("rst_wr_ready", 32'(a_wr_ready), 32'h1);
        check("rst_rd_valid", 32'(a_rd_valid), 32'h0);
        check("rst_overflow", 32'(a_ovf),      32'h0);
        check("rst_underflow",32'(a_unf),      32'h0);

        // Fill with 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'h11 * 32'(i + 1);
            set_a(1, 0, exp_w, 0);
            step();
            check("fill_level", 32'(a_level), 32'(i + 1));
            if (i == 4) check("fill_afull_l5", 32'(a_af), 32'h0);
            if (i == 5) check("fill_afull_l6", 32'(a_af), 32'h1);
        end
        set_a(0, 0, 0, 0);
        check("fill_full",     32'(a_full),     32'h1);
        check("fill_level8",   32'(a_level),    32'h8);
        check("fill_wr_ready", 32'(a_wr_ready), 32'h0);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'h11 * 32'(i + 1);
            check("drain_data", a_rd_data, exp_w);
            set_a(0, 1, 0, 0);
            step();
            check("drain_level", 32'(a_level), 32'(7 - i));
            if (i == 4) check("drain_aempty_l3", 32'(a_ae), 32'h0);
            if (i == 5) check("drain_aempty_l2", 32'(a_ae), 32'h1);
        end
        set_a(0, 0, 0, 0);
        check("drain_empty", 32'(a_empty), 32'h1);

        // Level 3, then 20 cycles of simultaneous push/pop across the wrap
        for (int i = 0; i < 3; i++) begin
            set_a(1, 0, 32'h100 + 32'(i), 0);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            check("stream_data", a_rd_data, 32'h100 + 32'(k));
            set_a(1, 1, 32'h103 + 32'(k), 0);
            step();
            check("stream_level", 32'(a_level), 32'h3);
        end
        set_a(0, 1, 0, 0);
        repeat (3) step();
        set_a(0, 0, 0, 0);
        check("stream_empty", 32'(a_empty), 32'h1);

        // Full plus simultaneous push/pop: pop taken, push refused
        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, 32'h200 + 32'(i), 0);
            step();
        end
        set_a(1, 1, 32'hDEAD, 0);
        step();
        set_a(0, 0, 0, 0);
        check("ovf_level",    32'(a_level), 32'h7);
        check("ovf_flag",     32'(a_ovf),   32'h1);
        check("ovf_full",     32'(a_full),  32'h0);
        check("ovf_head",     a_rd_data,    32'h201);
        set_a(0, 1, 0, 0);
        repeat (7) step();
        set_a(0, 0, 0, 0);
        check("unf_before",   32'(a_unf),   32'h0);
        set_a(0, 1, 0, 0);
        step();
        set_a(0, 0, 0, 0);
        check("unf_flag",     32'(a_unf),   32'h1);

        // Level 5 with overflow still set, then clr with a push pending
        for (int i = 0; i < 5; i++) begin
            set_a(1, 0, 32'h300 + 32'(i), 0);
            step();
        end
        set_a(0, 0, 0, 0);
        check("clr_pre_level", 32'(a_level), 32'h5);
        check("clr_pre_ovf",   32'(a_ovf),   32'h1);
        set_a(1, 0, 32'h999, 1);
        step();
        set_a(0, 0, 0, 0);
        check("clr_level", 32'(a_level), 32'h0);
        check("clr_ovf",   32'(a_ovf),   32'h0);
        check("clr_unf",   32'(a_unf),   32'h0);
        check("clr_empty", 32'(a_empty), 32'h1);
        step();
        check("clr_hold_empty", 32'(a_empty), 32'h1);

        // Wide build: 32 pushes reach full
        for (int i = 0; i < 32; i++) begin
            set_b(1, 0, 16'(i) ^ 16'h5A5A, 0);
            step();
        end
        set_b(0, 0, 0, 0);
        check("b_fill_level", 32'(b_level),    32'd32);
        check("b_fill_full",  32'(b_full),     32'h1);
        check("b_fill_ready", 32'(b_wr_ready), 32'h0);
        check("b_fill_head",  32'(b_rd_data),  32'h5A5A);

        // Randomised traffic on both instances, with a reset mid-burst
        for (int i = 0; i < 1600; i++) begin
            case ((i / 200) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 25; pr = 75; end
                default: begin pw = 55; pr = 55; end
            endcase
            if (i == 800) begin
                set_a(1, 0, 32'h7777, 0);
                set_b(1, 0, 16'h7777, 0);
                repeat (3) step();
                rst_n = 1'b0;
                reset_models();
                #1;
                check("mid_rst_level",    32'(a_level),    32'h0);
                check("mid_rst_empty",    32'(a_empty),    32'h1);
                check("mid_rst_aempty",   32'(a_ae),       32'h1);
                check("mid_rst_full",     32'(a_full),     32'h0);
                check("mid_rst_afull",    32'(a_af),       32'h0);
                check("mid_rst_ovf",      32'(a_ovf),      32'h0);
                check("mid_rst_unf",      32'(a_unf),      32'h0);
                check("mid_rst_wr_ready", 32'(a_wr_ready), 32'h1);
                check("mid_rst_rd_valid", 32'(a_rd_valid), 32'h0);
                check("mid_rst_b_level",  32'(b_level),    32'h0);
                check("mid_rst_b_empty",  32'(b_empty),    32'h1);
                set_a(0, 0, 0, 0);
                set_b(0, 0, 0, 0);
                repeat (2) step();
                rst_n = 1'b1;
                set_a(1, 0, 32'hABC0, 0);
                step();
                check("post_rst_head",  a_rd_data,       32'hABC0);
                check("post_rst_level", 32'(a_level),    32'h1);
                set_a(0, 1, 0, 0);
                step();
                check("post_rst_empty", 32'(a_empty),    32'h1);
            end
            set_a(($urandom_range(0, 99) < 32'(pw)), ($urandom_range(0, 99) < 32'(pr)),
                  $urandom, ($urandom_range(0, 99) < 2));
            set_b(($urandom_range(0, 99) < 32'(pw)), ($urandom_range(0, 99) < 32'(pr)),
                  16'($urandom), ($urandom_range(0, 199) < 1));
            step();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        step();
        @(negedge clk);
        #1;
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_nn_param_fifo
